idexe_pipe_stage: RTL and testbench

//  Parametrised successor to the ID/EX pipeline register: one elastic pipeline stage with a valid/ready handshake.
//  It adds stall, flush (bubble insertion), an optional 2-entry skid buffer and saturating stall/bubble counters.

---
 rtl/idexe_pipe_stage.sv | 125 ++++++++++++
 tb/tb_idexe_pipe_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/idexe_pipe_stage.sv
// rtl/idexe_pipe_stage.sv - elastic ID/EX pipeline stage with optional skid entry, flush and perf counters
// Reusable for EXE/MEM and MEM/WB by resizing CTRL_W/DATA_W.
module idexe_pipe_stage #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 137,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              acc, pop;

  assign out_valid  = (state_q != EMPTY);
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

  // SKID=1 keeps out_ready off the in_ready path; SKID=0 trades that for one entry
  always_comb begin
    if (SKID != 0) in_ready = (state_q != TWO) & ~flush & ~rst;
    else           in_ready = (~out_valid | out_ready) & ~flush & ~rst;
  end

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (acc && !pop && (SKID != 0)) begin
            state_d     = TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (acc) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (pop) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  // both counters look at the registered out_valid and stick at all-ones
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (!out_valid && (bubble_q != '1))            bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
    end
  end

endmodule

// File: tb/tb_idexe_pipe_stage.sv
// tb/tb_idexe_pipe_stage.sv - scoreboard bench for idexe_pipe_stage (SKID=1/CNT_W=4 and SKID=0 instances)
module tb_idexe_pipe_stage;
  localparam int CW = 8;
  localparam int DW = 137;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [3:0]    a_stall, a_bubble;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [15:0]   b_stall, b_bubble;

  idexe_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble));

  idexe_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble));

  int total = 0;
  int bad   = 0;
  logic [CW+DW-1:0] qa[$];
  logic [CW+DW-1:0] qb[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] v);
    a_in_valid = 1'b1;
    a_in_ctrl  = v;
    a_in_data  = DW'(v) * DW'(3);
  endtask

  task automatic drive_b(input logic [7:0] v);
    b_in_valid = 1'b1;
    b_in_ctrl  = v;
    b_in_data  = DW'(v) * DW'(3);
  endtask

  // scoreboard: accepted inputs are queued, each pop is compared in order
  always @(negedge clk) begin
    logic [CW+DW-1:0] e;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_out", 160'(a_out_ctrl), 160'(0) - 160'(1));
        else begin
          e = qa.pop_front();
          chk("a_out", 160'({a_out_ctrl, a_out_data}), 160'(e));
        end
      end
      if (!a_out_valid) chk("a_bubble_ctrl", 160'(a_out_ctrl), 160'(0));
      if (a_flush) qa.delete();
      if (a_in_valid && a_in_ready) qa.push_back({a_in_ctrl, a_in_data});

      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_out", 160'(b_out_ctrl), 160'(0) - 160'(1));
        else begin
          e = qb.pop_front();
          chk("b_out", 160'({b_out_ctrl, b_out_data}), 160'(e));
        end
      end
      if (!b_out_valid) chk("b_bubble_ctrl", 160'(b_out_ctrl), 160'(0));
      if (b_flush) qb.delete();
      if (b_in_valid && b_in_ready) qb.push_back({b_in_ctrl, b_in_data});
    end
  end

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_out_ready = 1'b1; drive_a(8'hAA);
    b_flush = 1'b0; b_out_ready = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0;

    // reset with in_valid held high
    tick(); tick();
    chk("rst_out_valid", 160'(a_out_valid), 160'(0));
    chk("rst_out_ctrl", 160'(a_out_ctrl), 160'(0));
    chk("rst_stall", 160'(a_stall), 160'(0));
    chk("rst_bubble", 160'(a_bubble), 160'(0));
    chk("rst_in_ready", 160'(a_in_ready), 160'(0));
    rst = 1'b0;
    a_in_valid = 1'b0;
    tick();
    chk("bubble_after_rst", 160'(a_bubble), 160'(1));

    // streaming at full rate
    for (int i = 0; i < 8; i++) begin
      drive_a(8'(i));
      tick();
      chk("stream_valid", 160'(a_out_valid), 160'(1));
      chk("stream_ctrl", 160'(a_out_ctrl), 160'(i));
    end
    a_in_valid = 1'b0;
    tick();
    chk("stream_stall", 160'(a_stall), 160'(0));

    // skid fill under backpressure, then drain
    a_out_ready = 1'b0;
    drive_a(8'h11); tick();
    drive_a(8'h22); tick();
    drive_a(8'h33); #1;
    chk("two_in_ready", 160'(a_in_ready), 160'(0));
    for (int h = 0; h < 2; h++) begin
      tick();
      chk("two_hold_ctrl", 160'(a_out_ctrl), 160'(8'h11));
      chk("two_hold_in_ready", 160'(a_in_ready), 160'(0));
    end
    a_out_ready = 1'b1;
    tick();
    chk("drain_b", 160'(a_out_ctrl), 160'(8'h22));
    tick();
    chk("drain_c", 160'(a_out_ctrl), 160'(8'h33));
    a_in_valid = 1'b0;
    tick();
    chk("drain_empty", 160'(a_out_valid), 160'(0));
    chk("held_stall", 160'(a_stall), 160'(3));

    // flush from TWO with a valid input present
    a_out_ready = 1'b0;
    drive_a(8'h44); tick();
    drive_a(8'h55); tick();
    a_flush = 1'b1;
    drive_a(8'h66); #1;
    chk("flush_in_ready", 160'(a_in_ready), 160'(0));
    tick();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    chk("flush_out_valid", 160'(a_out_valid), 160'(0));
    chk("flush_out_ctrl", 160'(a_out_ctrl), 160'(0));
    #1;
    chk("post_flush_in_ready", 160'(a_in_ready), 160'(1));
    a_out_ready = 1'b1;
    repeat (20) tick();
    chk("post_flush_idle", 160'(a_out_valid), 160'(0));
    chk("bubble_sat", 160'(a_bubble), 160'(15));
    chk("flush_stall", 160'(a_stall), 160'(5));

    // stall counter saturation at CNT_W=4
    a_out_ready = 1'b0;
    drive_a(8'h77); tick();
    a_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("stall_sat", 160'(a_stall), 160'((5 + k > 15) ? 15 : 5 + k));
    end
    a_out_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_stall", 160'(a_stall), 160'(0));
    chk("rst2_bubble", 160'(a_bubble), 160'(0));
    rst = 1'b0;

    // SKID=0: simultaneous pop and accept
    b_out_ready = 1'b1;
    drive_b(8'h21); tick();
    chk("b_first_valid", 160'(b_out_valid), 160'(1));
    chk("b_first_ctrl", 160'(b_out_ctrl), 160'(8'h21));
    drive_b(8'h42); #1;
    chk("b_pass_in_ready", 160'(b_in_ready), 160'(1));
    tick();
    chk("b_pass_valid", 160'(b_out_valid), 160'(1));
    chk("b_pass_ctrl", 160'(b_out_ctrl), 160'(8'h42));
    b_out_ready = 1'b0;
    drive_b(8'h63); #1;
    chk("b_stall_in_ready", 160'(b_in_ready), 160'(0));
    tick();
    chk("b_stall_hold", 160'(b_out_ctrl), 160'(8'h42));
    b_out_ready = 1'b1; #1;
    chk("b_release_in_ready", 160'(b_in_ready), 160'(1));
    tick();
    chk("b_release_ctrl", 160'(b_out_ctrl), 160'(8'h63));
    b_in_valid = 1'b0;
    tick();
    chk("b_end_valid", 160'(b_out_valid), 160'(0));
    chk("b_stall_cnt", 160'(b_stall), 160'(1));

    tick();
    chk("qa_drained", 160'(qa.size()), 160'(0));
    chk("qb_drained", 160'(qb.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
